// File: rtl/basic_g_checker.sv
// -----------------------------------------------------------------------------
// basic_g_checker
//
// Self-test sequencer and checker for the seven-output basic-gate block.
// On start it drives the gate inputs {a,b,c} through all 8 combinations. For
// each one it waits SETTLE cycles, samples y_in, and compares it against a
// built-in golden model. It reports pass/fail, the number of failing vectors,
// and a bitmap of which vectors failed.
//
// Parameters:
//   SETTLE  wait cycles between driving a vector and sampling y_in (1..15)
//   CNT_W   settle counter width; must be able to hold SETTLE-1
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   launches a run when sampled high in IDLE
//   a, b, c    out  registered gate inputs, {a,b,c} = current vector
//   y_in[6:0]  in   gate outputs y1..y7 (y_in[0] = y1)
//   busy       out  high while vectors are being driven and checked
//   done       out  one-cycle pulse at the end of a run
//   pass       out  last completed run had zero errors
//   err_count  out  failing vectors in the current/last run (0..8)
//   fail_vec   out  bit i set when vector i mismatched
// -----------------------------------------------------------------------------
module basic_g_checker #(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic [6:0] y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       vec_q,   vec_d;
    logic [2:0]       abc_q,   abc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [3:0]       err_q,   err_d;
    logic [7:0]       fv_q,    fv_d;
    logic             pass_q,  pass_d;
    logic             mismatch;

    // Expected y7..y1 for gate inputs {a,b,c}.
    function automatic logic [6:0] golden(input logic [2:0] abc);
        logic ga, gb, gc;
        ga = abc[2];
        gb = abc[1];
        gc = abc[0];
        return {~(ga ^ gb), ga ^ gb, ~(ga | gb), ~(ga & gb), ~gc, ga | gb, ga & gb};
    endfunction

    // Any differing bit fails the vector; several bad bits still count once.
    assign mismatch = (y_in != golden(abc_q));

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        vec_d   = vec_q;
        abc_d   = abc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    vec_d   = 3'd0;
                    abc_d   = 3'd0;
                    err_d   = 4'd0;
                    fv_d    = 8'd0;
                    pass_d  = 1'b0;
                end
            end
            S_DRIVE: begin
                cnt_d   = CNT_W'(SETTLE - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_d        = err_q + 4'd1;
                    fv_d[vec_q]  = 1'b1;
                end
                if (vec_q == 3'd7) begin
                    state_d = S_DONE;
                    // Uses the updated count so the last vector's result counts.
                    pass_d  = (err_d == 4'd0);
                end else begin
                    // a,b,c are loaded together with the DRIVE entry, so they are
                    // already valid during the DRIVE cycle.
                    vec_d   = vec_q + 3'd1;
                    abc_d   = vec_q + 3'd1;
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= 3'd0;
            abc_q   <= 3'd0;
            cnt_q   <= '0;
            err_q   <= 4'd0;
            fv_q    <= 8'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            abc_q   <= abc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            pass_q  <= pass_d;
        end
    end

    // Status decoded from the registered state, so it is glitch-free.
    assign busy      = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CHECK);
    assign done      = (state_q == S_DONE);
    assign a         = abc_q[2];
    assign b         = abc_q[1];
    assign c         = abc_q[0];
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fv_q;

endmodule

// File: tb/tb_basic_g_checker.sv
// -----------------------------------------------------------------------------
// Bench for basic_g_checker. Two instances are used: SETTLE=1 (index 0) and
// SETTLE=3 (index 1). The gate block is emulated in the bench, with selectable
// faults and an optional glitch. A timeline model predicts every output from
// the number of cycles since launch.
// -----------------------------------------------------------------------------
module tb_basic_g_checker;

    localparam int S0 = 1;
    localparam int S1 = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start     [2];
    logic [6:0] y_in      [2];
    logic       a_o       [2];
    logic       b_o       [2];
    logic       c_o       [2];
    logic       busy_o    [2];
    logic       done_o    [2];
    logic       pass_o    [2];
    logic [3:0] err_o     [2];
    logic [7:0] fv_o      [2];

    int         fm        [2];          // 0 good, 1 y3 stuck-0, 2 y6/y7 swapped
    logic [6:0] glitch    [2] = '{7'h00, 7'h00};
    bit         glitch_en = 1'b0;
    bit         cmp_en    = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Timeline model: run_t = cycles since the launch edge (-1 when idle).
    int         run_t  [2] = '{-1, -1};
    logic [2:0] m_abc  [2] = '{3'd0, 3'd0};
    int         m_err  [2] = '{0, 0};
    logic [7:0] m_fv   [2] = '{8'd0, 8'd0};
    bit         m_pass [2] = '{1'b0, 1'b0};
    int         m_v;

    always #5 clk = ~clk;

    basic_g_checker #(.SETTLE(S0), .CNT_W(4)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .a(a_o[0]), .b(b_o[0]), .c(c_o[0]), .y_in(y_in[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .err_count(err_o[0]), .fail_vec(fv_o[0])
    );

    basic_g_checker #(.SETTLE(S1), .CNT_W(4)) dut_s3 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .a(a_o[1]), .b(b_o[1]), .c(c_o[1]), .y_in(y_in[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .err_count(err_o[1]), .fail_vec(fv_o[1])
    );

    function automatic int period(input int i);
        return (i == 0) ? S0 + 2 : S1 + 2;
    endfunction

    function automatic int settle(input int i);
        return (i == 0) ? S0 : S1;
    endfunction

    // Gate truth table, returned as {y7..y1}.
    function automatic logic [6:0] golden(input logic [2:0] v);
        logic ga, gb, gc;
        ga = v[2];
        gb = v[1];
        gc = v[0];
        return {~(ga ^ gb), ga ^ gb, ~(ga | gb), ~(ga & gb), ~gc, ga | gb, ga & gb};
    endfunction

    // Emulated block under test, optionally faulty.
    function automatic logic [6:0] gate_out(input logic [2:0] v, input int mode);
        logic [6:0] g;
        g = golden(v);
        if (mode == 1) g[2] = 1'b0;
        if (mode == 2) g = {g[5], g[6], g[4:0]};
        return g;
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            y_in[i] = gate_out({a_o[i], b_o[i], c_o[i]}, fm[i]) ^ glitch[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model update, from the inputs the DUT samples on the same edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                run_t[i]  = -1;
                m_abc[i]  = 3'd0;
                m_err[i]  = 0;
                m_fv[i]   = 8'd0;
                m_pass[i] = 1'b0;
            end else if (run_t[i] < 0) begin
                if (start[i]) begin
                    run_t[i]  = 0;
                    m_abc[i]  = 3'd0;
                    m_err[i]  = 0;
                    m_fv[i]   = 8'd0;
                    m_pass[i] = 1'b0;
                end
            end else if (run_t[i] == 8 * period(i)) begin
                run_t[i] = -1;
            end else begin
                run_t[i] = run_t[i] + 1;
                if (run_t[i] % period(i) == 0) begin
                    m_v = run_t[i] / period(i) - 1;
                    if (gate_out(3'(m_v), fm[i]) != golden(3'(m_v))) begin
                        m_err[i]     = m_err[i] + 1;
                        m_fv[i][m_v] = 1'b1;
                    end
                    if (run_t[i] == 8 * period(i)) m_pass[i] = (m_err[i] == 0);
                    else                           m_abc[i]  = 3'(m_v + 1);
                end
            end
        end
    end

    // Glitch y_in across the WAIT window of the SETTLE=3 instance only.
    always @(negedge clk) begin
        if (glitch_en && run_t[1] >= 0 && run_t[1] < 8 * period(1) &&
            (run_t[1] % period(1)) >= 1 && (run_t[1] % period(1)) <= settle(1))
            glitch[1] = 7'h7F;
        else
            glitch[1] = 7'h00;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("i%0d_abc", i), 32'({a_o[i], b_o[i], c_o[i]}), 32'(m_abc[i]));
                check($sformatf("i%0d_busy", i), 32'(busy_o[i]),
                      32'(run_t[i] >= 0 && run_t[i] < 8 * period(i)));
                check($sformatf("i%0d_done", i), 32'(done_o[i]), 32'(run_t[i] == 8 * period(i)));
                check($sformatf("i%0d_pass", i), 32'(pass_o[i]), 32'(m_pass[i]));
                check($sformatf("i%0d_err", i), 32'(err_o[i]), 32'(m_err[i]));
                check($sformatf("i%0d_fv", i), 32'(fv_o[i]), 32'(m_fv[i]));
            end
        end
    end

    task automatic launch(input int i);
        @(negedge clk);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    // k counts negedges after the launch edge; the launch task returns at k=0.
    task automatic wait_done(input int i, input int k0, output int k);
        k = k0;
        while (done_o[i] !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) begin
            checks++;
            failures++;
            $display("FAIL i%0d_done_timeout: got no done expected done", i);
        end
    endtask

    int k;
    int n_done;
    int pos0;
    int pos1;

    initial begin
        rst_n    = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        fm[0]    = 0;
        fm[1]    = 0;
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_abc", 32'({a_o[0], b_o[0], c_o[0]}), 32'd0);
        check("rst_busy", 32'(busy_o[0]), 32'd0);
        check("rst_err", 32'(err_o[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Good block: full sweep, done at cycle 24.
        launch(0);
        wait_done(0, 0, k);
        check("t1_done_cycle", 32'(k), 32'd24);
        check("t1_pass", 32'(pass_o[0]), 32'd1);
        check("t1_err", 32'(err_o[0]), 32'd0);
        check("t1_fv", 32'(fv_o[0]), 32'h00);
        check("t1_model_pass", 32'(m_pass[0]), 32'd1);

        // y3 stuck at 0: vectors with c=0 fail.
        fm[0] = 1;
        launch(0);
        wait_done(0, 0, k);
        check("t2_err", 32'(err_o[0]), 32'd4);
        check("t2_fv", 32'(fv_o[0]), 32'h55);
        check("t2_pass", 32'(pass_o[0]), 32'd0);
        check("t2_model_fv", 32'(m_fv[0]), 32'h55);

        // y6/y7 swapped: every vector fails.
        fm[0] = 2;
        launch(0);
        wait_done(0, 0, k);
        check("t3_err", 32'(err_o[0]), 32'd8);
        check("t3_fv", 32'(fv_o[0]), 32'hFF);
        check("t3_pass", 32'(pass_o[0]), 32'd0);
        check("t3_model_err", 32'(m_err[0]), 32'd8);

        // start re-pulsed during vector 3 is ignored.
        fm[0] = 0;
        launch(0);
        repeat (10) @(negedge clk);
        check("t4_vec3", 32'({a_o[0], b_o[0], c_o[0]}), 32'd3);
        check("t4_busy", 32'(busy_o[0]), 32'd1);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, 11, k);
        check("t4_done_cycle", 32'(k), 32'd24);
        n_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_o[0] === 1'b1) n_done++;
        end
        check("t4_extra_done", 32'(n_done), 32'd0);

        // Reset during WAIT of vector 5 abandons the run.
        fm[0] = 1;
        launch(0);
        repeat (16) @(negedge clk);
        check("t5_pre_err", 32'(err_o[0]), 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_abc", 32'({a_o[0], b_o[0], c_o[0]}), 32'd0);
        check("t5_busy", 32'(busy_o[0]), 32'd0);
        check("t5_err", 32'(err_o[0]), 32'd0);
        check("t5_fv", 32'(fv_o[0]), 32'h00);
        n_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_o[0] === 1'b1) n_done++;
        end
        check("t5_no_done", 32'(n_done), 32'd0);
        fm[0] = 0;
        launch(0);
        wait_done(0, 0, k);
        check("t5_clean_cycle", 32'(k), 32'd24);
        check("t5_clean_pass", 32'(pass_o[0]), 32'd1);

        // start held high: back-to-back runs, done at 24 and 50.
        repeat (2) @(negedge clk);
        start[0] = 1'b1;
        n_done = 0;
        pos0 = -1;
        pos1 = -1;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (j == 30) start[0] = 1'b0;
            if (done_o[0] === 1'b1) begin
                if (n_done == 0) pos0 = j;
                else             pos1 = j;
                n_done++;
            end
        end
        check("t6_done_count", 32'(n_done), 32'd2);
        check("t6_first_done", 32'(pos0), 32'd24);
        check("t6_second_done", 32'(pos1), 32'd50);

        // SETTLE=3 with glitches during WAIT: done at 40, no errors.
        glitch_en = 1'b1;
        launch(1);
        wait_done(1, 0, k);
        check("t7_done_cycle", 32'(k), 32'd40);
        check("t7_pass", 32'(pass_o[1]), 32'd1);
        check("t7_err", 32'(err_o[1]), 32'd0);
        check("t7_fv", 32'(fv_o[1]), 32'h00);
        glitch_en = 1'b0;
        repeat (3) @(negedge clk);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/basic_g_checker.md
Name: basic_g_checker

Overview:
- Self-test sequencer and checker for the team's seven-output basic-gate block.
- Acts as the opposite end of that block's interface: it drives the gate inputs a, b, c and receives and checks outputs y1..y7.
- On start, it walks all 8 input combinations, waits a settle time, compares the gate outputs against a built-in golden model, and reports pass/fail, the error count and which vectors failed.
- Used on-board or in simulation to validate gate-level and dataflow implementations.

Parameters:
- SETTLE, 1, wait cycles between driving a vector and sampling y_in; legal range 1..15.
- CNT_W, 4, width of the internal settle counter; must hold SETTLE.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  level sampled in IDLE; 1 launches a test run.
- a  out  1  gate input a; registered; equals vec[2].
- b  out  1  gate input b; registered; equals vec[1].
- c  out  1  gate input c; registered; equals vec[0].
- y_in  in  7  gate outputs returned from the block under test; y_in[0]=y1 … y_in[6]=y7.
- busy  out  1  high from DRIVE of vector 0 through CHECK of vector 7.
- done  out  1  one-cycle pulse in the DONE state.
- pass  out  1  1 when the last completed run had zero errors; held until the next start.
- err_count  out  4  number of failing vectors in the current or last run, 0..8.
- fail_vec  out  8  bit i set when vector i = {a,b,c} mismatched.

Behaviour:
- Reset (rst_n=0 at a rising edge), required register values:
  - state=IDLE, vec=0
  - a=b=c=0
  - busy=0, done=0, pass=0
  - err_count=0, fail_vec=0
- Reset is honoured in any state, including mid-run; the run is abandoned and no done pulse is issued.
- Golden model, per vector:
  - y1=a&b, y2=a|b, y3=~c
  - y4=~(a&b), y5=~(a|b)
  - y6=a^b, y7=~(a^b)
- Mismatch rule: a vector fails if any of the 7 bits differ. A vector with multiple bad bits counts once.
- FSM states: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE:
  - busy=0; a,b,c hold their last values.
  - start=1 leads to DRIVE with vec=0, err_count=0, fail_vec=0, pass=0.
- DRIVE (1 cycle):
  - a,b,c are registered from vec, visible from this cycle.
  - The settle counter loads SETTLE-1.
  - Next state is WAIT.
- WAIT (SETTLE cycles):
  - The counter decrements each cycle.
  - When the counter reaches 0, the next state is CHECK.
- CHECK (1 cycle):
  - y_in is sampled and compared against the golden model for the current a,b,c.
  - On mismatch: err_count+1 and fail_vec[vec]=1, both registered at the end of this cycle.
  - If vec==7, the next state is DONE; otherwise vec+1 and the next state is DRIVE.
- DONE (1 cycle):
  - done=1, busy=0.
  - pass=(err_count==0), registered on entry to DONE.
  - Next state is IDLE.
- Timing:
  - Cycles per vector = SETTLE+2.
  - done is asserted 8*(SETTLE+2) cycles after the edge that samples start=1 in IDLE. For SETTLE=1 that is 24 cycles.
- start outside IDLE is ignored; there is no restart mid-run.
- start held high causes back-to-back runs: the machine returns to IDLE, then re-launches on the next edge.
- err_count cannot overflow (maximum 8 fits in 4 bits); no saturation logic is needed.
- vec is 3 bits; the increment from 7 never occurs because the transition goes to DONE.
- a,b,c change only on entry to DRIVE, so y_in is stable for SETTLE+1 cycles before sampling.

Test Plan:
- Correct gate model on y_in, SETTLE=1, start pulse → a,b,c step 000..111; done pulses 24 cycles after start; pass=1, err_count=0, fail_vec=8'h00.
- y_in[2] (y3) stuck at 0 → vectors 0,2,4,6 fail; err_count=4, fail_vec=8'h55, pass=0.
- y6/y7 swapped on y_in → every vector fails; err_count=8, fail_vec=8'hFF, pass=0.
- start re-pulsed while busy=1 at vector 3 → ignored; a single done pulse at the original cycle 24.
- rst_n=0 for one cycle during WAIT of vector 5 → next cycle: state IDLE, a=b=c=0, busy=0, err_count=0, fail_vec=0, and no done pulse; a following start gives a clean full run.
- SETTLE=3, correct model → done 40 cycles after start; y_in is sampled only in CHECK, after 4 stable cycles (glitch injected on y_in during WAIT causes no error).
